// File: rtl/regfile_writeback_pkg.sv
// Shared types for the integer register-file write side.
// The wb_req_t struct is also used by the decode hazard logic.
package regfile_writeback_pkg;
  localparam int REG_IDX_W = 5;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;

  typedef struct packed {
    logic [REG_IDX_W-1:0] rd;
    logic [XLEN-1:0]      data;
  } wb_req_t;

  function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_IDX_W-1:0] rd);
    rd_onehot     = '0;
    rd_onehot[rd] = 1'b1;
  endfunction
endpackage

// File: rtl/regfile_writeback_wb_fifo.sv
// Synchronous FIFO for long-latency results.
// Also exposes a per-entry valid/rd view used to build the busy mask.
module wb_fifo
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [REG_IDX_W-1:0]              push_rd,
  input  logic [XLEN-1:0]                   push_data,
  input  logic                              pop,
  output logic [REG_IDX_W-1:0]              head_rd,
  output logic [XLEN-1:0]                   head_data,
  output logic [$clog2(DEPTH):0]            count,
  output logic [DEPTH-1:0]                  entry_vld,
  output logic [DEPTH-1:0][REG_IDX_W-1:0]   entry_rd
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t [DEPTH-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q].rd   = push_rd;
      mem_d[wr_ptr_q].data = push_data;
      wr_ptr_d             = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_rd   = mem_q[rd_ptr_q].rd;
  assign head_data = mem_q[rd_ptr_q].data;
  assign count     = count_q;

  // Slot i is live when its distance past the read pointer is below the occupancy.
  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [PTR_W-1:0] offs;
    assign offs         = PTR_W'(i) - rd_ptr_q;
    assign entry_vld[i] = {1'b0, offs} < count_q;
    assign entry_rd[i]  = mem_q[i].rd;
  end
endmodule

// File: rtl/regfile_writeback.sv
// Register-file write port owner: ALU results take priority, buffered
// load/mul results drain through a FIFO with a starvation guard.
module regfile_writeback
  import regfile_writeback_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [4:0]             a_rd,
  input  logic [31:0]            a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [4:0]             b_rd,
  input  logic [31:0]            b_data,
  output logic                   wb_en,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic [31:0]            busy_mask,
  output logic [$clog2(DEPTH):0] fifo_count
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ST_W  = $clog2(STARVE_LIMIT + 1);

  logic [ST_W-1:0]                starve_q, starve_d;
  logic                           wb_en_q, wb_en_d;
  logic [REG_IDX_W-1:0]           wb_rd_q, wb_rd_d;
  logic [XLEN-1:0]                wb_data_q, wb_data_d;
  logic                           fifo_empty, grant_a, pop, push;
  logic [REG_IDX_W-1:0]           head_rd;
  logic [XLEN-1:0]                head_data;
  logic [DEPTH-1:0]               entry_vld;
  logic [DEPTH-1:0][REG_IDX_W-1:0] entry_rd;

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_rd   (b_rd),
    .push_data (b_data),
    .pop       (pop),
    .head_rd   (head_rd),
    .head_data (head_data),
    .count     (fifo_count),
    .entry_vld (entry_vld),
    .entry_rd  (entry_rd)
  );

  assign fifo_empty = (fifo_count == '0);
  assign a_ready    = (starve_q != ST_W'(STARVE_LIMIT));
  assign b_ready    = (fifo_count < CNT_W'(DEPTH));
  assign grant_a    = a_valid && a_ready;
  assign pop        = !grant_a && !fifo_empty;
  // rd 0 results are accepted but never buffered.
  assign push       = b_valid && b_ready && (b_rd != '0);

  always_comb begin
    wb_en_d   = 1'b0;
    wb_rd_d   = wb_rd_q;
    wb_data_d = wb_data_q;
    starve_d  = starve_q;
    if (grant_a) begin
      if (a_rd != '0) begin
        wb_en_d   = 1'b1;
        wb_rd_d   = a_rd;
        wb_data_d = a_data;
      end
    end else if (pop) begin
      wb_en_d   = 1'b1;
      wb_rd_d   = head_rd;
      wb_data_d = head_data;
    end
    if (pop || fifo_empty) starve_d = '0;
    else if (grant_a)      starve_d = starve_q + ST_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q  <= '0;
      wb_en_q   <= 1'b0;
      wb_rd_q   <= '0;
      wb_data_q <= '0;
    end else begin
      starve_q  <= starve_d;
      wb_en_q   <= wb_en_d;
      wb_rd_q   <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  end

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < DEPTH; i++)
      if (entry_vld[i]) busy_mask = busy_mask | rd_onehot(entry_rd[i]);
    busy_mask[0] = 1'b0;
  end

  assign wb_en   = wb_en_q;
  assign wb_rd   = wb_rd_q;
  assign wb_data = wb_data_q;
endmodule
